// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU operation codes, NZCV bit
// positions and the per-requester response buffer state encoding.
package alu_arbiter_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_ORR  = 3'b011;
   localparam logic [2:0] ALU_EOR  = 3'b100;
   localparam logic [2:0] ALU_SMUL = 3'b110;
   localparam logic [2:0] ALU_MUL  = 3'b111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                            input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single combinational ALU shared by both requesters. C follows the
// "carry = no borrow" convention on SUB; logic and multiply ops clear C and V.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        ctrl,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags
);

   logic [DATA_W:0]   add_s;
   logic [DATA_W:0]   sub_s;
   logic [DATA_W-1:0] mul_s;
   logic [DATA_W-1:0] smul_s;
   logic              c_s;
   logic              v_s;

   assign add_s  = {1'b0, a} + {1'b0, b};
   assign sub_s  = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
   assign mul_s  = a * b;
   assign smul_s = $signed(a) * $signed(b);

   // Operation select; the unassigned code 101 falls to a zero result.
   always_comb begin
      result = {DATA_W{1'b0}};
      c_s    = 1'b0;
      v_s    = 1'b0;
      case (ctrl)
         ALU_ADD: begin
            result = add_s[DATA_W-1:0];
            c_s    = add_s[DATA_W];
            v_s    = (a[DATA_W-1] == b[DATA_W-1]) && (add_s[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_SUB: begin
            result = sub_s[DATA_W-1:0];
            c_s    = sub_s[DATA_W];
            v_s    = (a[DATA_W-1] != b[DATA_W-1]) && (sub_s[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_AND:  result = a & b;
         ALU_ORR:  result = a | b;
         ALU_EOR:  result = a ^ b;
         ALU_SMUL: result = smul_s;
         ALU_MUL:  result = mul_s;
         default:  result = {DATA_W{1'b0}};
      endcase
   end

   // Flag assembly from the selected result.
   always_comb begin
      flags = pack_nzcv(result[DATA_W-1], (result == {DATA_W{1'b0}}), c_s, v_s);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a one-entry response buffer per requester and the NZCV flags register.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int unsigned PRIO_RST = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [2:0]        req0_ctrl,
   input  logic              req0_sf,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic [3:0]        rsp0_flags,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [2:0]        req1_ctrl,
   input  logic              req1_sf,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic [3:0]        rsp1_flags,
   output logic [3:0]        flags_q
);

   buf_state_e        buf0_state_r, buf0_state_s;
   buf_state_e        buf1_state_r, buf1_state_s;
   logic              prio_r;
   logic              elig0_s, elig1_s;
   logic              grant0_s, grant1_s;
   logic [DATA_W-1:0] alu_a_s, alu_b_s, alu_result_s;
   logic [2:0]        alu_ctrl_s;
   logic [3:0]        alu_flags_s;
   logic              alu_sf_s;
   logic [DATA_W-1:0] rsp0_result_r, rsp1_result_r;
   logic [3:0]        rsp0_flags_r, rsp1_flags_r, flags_r;

   // A granted buffer is always (re)filled; otherwise a consumed entry drains.
   function automatic buf_state_e buf_next(input buf_state_e state, input logic grant,
                                           input logic drain);
      buf_state_e nxt;
      case (state)
         BUF_EMPTY: nxt = grant ? BUF_FULL : BUF_EMPTY;
         BUF_FULL: begin
            if (grant)      nxt = BUF_FULL;
            else if (drain) nxt = BUF_EMPTY;
            else            nxt = BUF_FULL;
         end
         default:   nxt = BUF_EMPTY;
      endcase
      return nxt;
   endfunction

   // Eligibility and single-winner grant; readies are held low during reset.
   always_comb begin
      elig0_s = req0_valid && ((buf0_state_r == BUF_EMPTY) || rsp0_ready);
      elig1_s = req1_valid && ((buf1_state_r == BUF_EMPTY) || rsp1_ready);
      if (!reset) begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end else if (elig0_s && elig1_s) begin
         grant0_s = (prio_r == 1'b0);
         grant1_s = (prio_r == 1'b1);
      end else begin
         grant0_s = elig0_s;
         grant1_s = elig1_s;
      end
   end

   // Operand mux feeding the shared ALU.
   always_comb begin
      if (grant1_s) begin
         alu_a_s    = req1_a;
         alu_b_s    = req1_b;
         alu_ctrl_s = req1_ctrl;
      end else begin
         alu_a_s    = req0_a;
         alu_b_s    = req0_b;
         alu_ctrl_s = req0_ctrl;
      end
      alu_sf_s = (grant0_s && req0_sf) || (grant1_s && req1_sf);
   end

   alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (alu_a_s),
      .b      (alu_b_s),
      .ctrl   (alu_ctrl_s),
      .result (alu_result_s),
      .flags  (alu_flags_s)
   );

   // Buffer state registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         buf0_state_r <= BUF_EMPTY;
         buf1_state_r <= BUF_EMPTY;
      end else begin
         buf0_state_r <= buf0_state_s;
         buf1_state_r <= buf1_state_s;
      end
   end

   // Buffer next-state logic.
   always_comb begin
      buf0_state_s = buf_next(buf0_state_r, grant0_s, rsp0_ready);
      buf1_state_s = buf_next(buf1_state_r, grant1_s, rsp1_ready);
   end

   // Handshake outputs decoded from the arbiter and buffer states.
   always_comb begin
      req0_ready  = grant0_s;
      req1_ready  = grant1_s;
      rsp0_valid  = (buf0_state_r == BUF_FULL);
      rsp1_valid  = (buf1_state_r == BUF_FULL);
      rsp0_result = rsp0_result_r;
      rsp1_result = rsp1_result_r;
      rsp0_flags  = rsp0_flags_r;
      rsp1_flags  = rsp1_flags_r;
      flags_q     = flags_r;
   end

   // Priority pointer: moves to the loser after every grant.
   always_ff @(posedge clk) begin
      if (!reset)        prio_r <= PRIO_RST[0];
      else if (grant0_s) prio_r <= 1'b1;
      else if (grant1_s) prio_r <= 1'b0;
      else               prio_r <= prio_r;
   end

   // Response payloads and architectural flags captured on the grant edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rsp0_result_r <= {DATA_W{1'b0}};
         rsp1_result_r <= {DATA_W{1'b0}};
         rsp0_flags_r  <= 4'b0000;
         rsp1_flags_r  <= 4'b0000;
         flags_r       <= 4'b0000;
      end else begin
         if (grant0_s) begin
            rsp0_result_r <= alu_result_s;
            rsp0_flags_r  <= alu_flags_s;
         end
         if (grant1_s) begin
            rsp1_result_r <= alu_result_s;
            rsp1_flags_r  <= alu_flags_s;
         end
         if (alu_sf_s) flags_r <= alu_flags_s;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: reset, single op, contention,
// backpressure, drain+refill and reset with both buffers full.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        clk, reset;
   logic        req0_valid, req0_ready, req0_sf, rsp0_valid, rsp0_ready;
   logic [31:0] req0_a, req0_b, rsp0_result;
   logic [2:0]  req0_ctrl;
   logic [3:0]  rsp0_flags;
   logic        req1_valid, req1_ready, req1_sf, rsp1_valid, rsp1_ready;
   logic [31:0] req1_a, req1_b, rsp1_result;
   logic [2:0]  req1_ctrl;
   logic [3:0]  rsp1_flags;
   logic [3:0]  flags_q;
   int          n_tests, n_fail;

   alu_arbiter #(.DATA_W(32), .PRIO_RST(0)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl), .req0_sf(req0_sf), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl), .req1_sf(req1_sf), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
      .flags_q(flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic set0(input logic v, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic sf);
      req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; req0_sf = sf;
   endtask

   task automatic set1(input logic v, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic sf);
      req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; req1_sf = sf;
   endtask

   task automatic test_reset;
      set0(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b0);
      set1(1'b1, ALU_ADD, 32'd5, 32'd6, 1'b1);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", {req0_ready, req1_ready}); end
         n_tests++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 00", {rsp0_valid, rsp1_valid}); end
         n_tests++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", flags_q); end
      end
      reset = 1'b1;
      settle();
      n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL release_first_grant: got %b exp 10", {req0_ready, req1_ready}); end
      n_tests++; if ({rsp0_valid, rsp1_valid, flags_q} !== 6'b000000) begin n_fail++; $display("FAIL release_state: got %b exp 000000", {rsp0_valid, rsp1_valid, flags_q}); end
      tick();
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      n_tests++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_fail++; $display("FAIL first_rsp_valid: got %b exp 10", {rsp0_valid, rsp1_valid}); end
      n_tests++; if (rsp0_result !== 32'd3) begin n_fail++; $display("FAIL first_result: got %h exp %h", rsp0_result, 32'd3); end
      n_tests++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL first_sf0_hold: got %b exp 0000", flags_q); end
      tick();
      n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL first_drain: got %b exp 0", rsp0_valid); end
   endtask

   task automatic test_single_op;
      rsp0_ready = 1'b0;
      set0(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
      settle();
      n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b exp 1", req0_ready); end
      tick();
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      n_tests++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", rsp0_valid); end
      n_tests++; if (rsp0_result !== 32'h8000_0000) begin n_fail++; $display("FAIL single_result: got %h exp %h", rsp0_result, 32'h8000_0000); end
      n_tests++; if (rsp0_flags !== 4'b1001) begin n_fail++; $display("FAIL single_rsp_flags: got %b exp 1001", rsp0_flags); end
      n_tests++; if (flags_q !== 4'b1001) begin n_fail++; $display("FAIL single_flags_q: got %b exp 1001", flags_q); end
      rsp0_ready = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back;
      rsp1_ready = 1'b1;
      set1(1'b1, ALU_ORR, 32'h0000_00F0, 32'h0000_000F, 1'b0);
      settle();
      n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_a: got %b exp 1", req1_ready); end
      tick();
      n_tests++; if (rsp1_result !== 32'h0000_00FF || rsp1_flags !== 4'b0000) begin n_fail++; $display("FAIL b2b_orr: got %h/%b exp 000000ff/0000", rsp1_result, rsp1_flags); end
      n_tests++; if (flags_q !== 4'b1001) begin n_fail++; $display("FAIL b2b_flags_hold: got %b exp 1001", flags_q); end
      set1(1'b1, 3'b101, 32'd7, 32'd9, 1'b1);
      settle();
      n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_b: got %b exp 1", req1_ready); end
      tick();
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      n_tests++; if ({rsp1_valid, rsp1_result, rsp1_flags} !== {1'b1, 32'd0, 4'b0100}) begin n_fail++; $display("FAIL b2b_rsvd: got %b/%h/%b exp 1/00000000/0100", rsp1_valid, rsp1_result, rsp1_flags); end
      n_tests++; if (flags_q !== 4'b0100) begin n_fail++; $display("FAIL b2b_rsvd_flags_q: got %b exp 0100", flags_q); end
      tick();
   endtask

   task automatic test_contention;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set0(1'b1, ALU_SUB, 32'd5, 32'd5, 1'b1);
      set1(1'b1, ALU_MUL, 32'd3, 32'd4, 1'b0);
      settle();
      n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_grant1: got %b exp 10", {req0_ready, req1_ready}); end
      tick();
      n_tests++; if ({rsp0_result, rsp0_flags} !== {32'd0, 4'b0110}) begin n_fail++; $display("FAIL cont_sub: got %h/%b exp 00000000/0110", rsp0_result, rsp0_flags); end
      set0(1'b1, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
      settle();
      n_tests++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL cont_grant2: got %b exp 01", {req0_ready, req1_ready}); end
      tick();
      n_tests++; if ({rsp1_result, rsp1_flags} !== {32'd12, 4'b0000}) begin n_fail++; $display("FAIL cont_mul: got %h/%b exp 0000000c/0000", rsp1_result, rsp1_flags); end
      set1(1'b1, ALU_SMUL, 32'hFFFF_FFFD, 32'd4, 1'b0);
      settle();
      n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_grant3: got %b exp 10", {req0_ready, req1_ready}); end
      tick();
      n_tests++; if ({rsp0_result, rsp0_flags} !== {32'h0F00_0F00, 4'b0000}) begin n_fail++; $display("FAIL cont_and: got %h/%b exp 0f000f00/0000", rsp0_result, rsp0_flags); end
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      settle();
      n_tests++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL cont_grant4: got %b exp 01", {req0_ready, req1_ready}); end
      tick();
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      n_tests++; if ({rsp1_result, rsp1_flags} !== {32'hFFFF_FFF4, 4'b1000}) begin n_fail++; $display("FAIL cont_smul: got %h/%b exp fffffff4/1000", rsp1_result, rsp1_flags); end
      n_tests++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL cont_flags_q: got %b exp 0110", flags_q); end
      tick();
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_v;
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      set1(1'b1, ALU_EOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0);
      tick();
      set1(1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         set0(1'b1, ALU_ADD, 32'd10 + 32'(i), 32'd100, 1'b0);
         settle();
         n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b exp 10", i, {req0_ready, req1_ready}); end
         n_tests++; if ({rsp1_valid, rsp1_result} !== {1'b1, 32'h5555_5555}) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h exp 1/55555555", i, rsp1_valid, rsp1_result); end
         tick();
         exp_v = 32'd110 + 32'(i);
         n_tests++; if (rsp0_result !== exp_v) begin n_fail++; $display("FAIL bp_port0[%0d]: got %h exp %h", i, rsp0_result, exp_v); end
      end
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      rsp1_ready = 1'b1;
      settle();
      n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b exp 1", req1_ready); end
      tick();
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      n_tests++; if (rsp1_result !== 32'd2) begin n_fail++; $display("FAIL bp_after: got %h exp %h", rsp1_result, 32'd2); end
      tick();
   endtask

   task automatic test_drain_refill;
      rsp0_ready = 1'b0;
      set0(1'b1, ALU_ORR, 32'd1, 32'd2, 1'b0);
      tick();
      n_tests++; if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL dr_fill: got %b/%h exp 1/00000003", rsp0_valid, rsp0_result); end
      rsp0_ready = 1'b1;
      set0(1'b1, ALU_EOR, 32'h0000_000F, 32'h0000_000F, 1'b0);
      settle();
      n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL dr_ready: got %b exp 1", req0_ready); end
      tick();
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      n_tests++; if ({rsp0_valid, rsp0_result, rsp0_flags} !== {1'b1, 32'd0, 4'b0100}) begin n_fail++; $display("FAIL dr_refill: got %b/%h/%b exp 1/00000000/0100", rsp0_valid, rsp0_result, rsp0_flags); end
   endtask

   task automatic test_reset_midflight;
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set1(1'b1, ALU_SUB, 32'd2, 32'd3, 1'b1);
      tick();
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      set0(1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
      tick();
      n_tests++; if ({rsp0_valid, rsp1_valid, flags_q} !== 6'b111000) begin n_fail++; $display("FAIL mf_full: got %b exp 111000", {rsp0_valid, rsp1_valid, flags_q}); end
      n_tests++; if (rsp1_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mf_sub: got %h exp ffffffff", rsp1_result); end
      reset = 1'b0;
      set0(1'b1, ALU_ORR, 32'h0000_0010, 32'h0000_0001, 1'b0);
      set1(1'b1, ALU_ADD, 32'd8, 32'd8, 1'b0);
      settle();
      n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL mf_ready_in_reset: got %b exp 00", {req0_ready, req1_ready}); end
      tick();
      n_tests++; if ({rsp0_valid, rsp1_valid, flags_q} !== 6'b000000) begin n_fail++; $display("FAIL mf_cleared: got %b exp 000000", {rsp0_valid, rsp1_valid, flags_q}); end
      n_tests++; if ({rsp0_result, rsp1_result} !== 64'd0) begin n_fail++; $display("FAIL mf_results: got %h/%h exp 0/0", rsp0_result, rsp1_result); end
      reset = 1'b1;
      settle();
      n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL mf_prio: got %b exp 10", {req0_ready, req1_ready}); end
      tick();
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      n_tests++; if ({rsp0_valid, rsp0_result, rsp1_valid} !== {1'b1, 32'h0000_0011, 1'b0}) begin n_fail++; $display("FAIL mf_after: got %b/%h/%b exp 1/00000011/0", rsp0_valid, rsp0_result, rsp1_valid); end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set0(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      set1(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
      test_reset();
      test_single_op();
      test_back_to_back();
      test_contention();
      test_backpressure();
      test_drain_refill();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: the multi-cycle datapath controller (port 0) and the address/auxiliary sequencer (port 1).
- Round-robin arbitration with valid/ready handshakes on both sides.
- One registered response buffer per requester.
- Owns the architectural NZCV flags register, updated on requests that set flags.

Parameters:
- DATA_W, 32, operand/result width; fixed by the ALU.
- PRIO_RST, 0, requester index that holds priority after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  DATA_W each  operands
- req0_ctrl  in  3  ALU control code
- req0_sf  in  1  update flags_q with this op's flags
- rsp0_valid  out  1  response 0 available
- rsp0_ready  in  1  requester 0 consumes response
- rsp0_result  out  DATA_W  held result
- rsp0_flags  out  4  held {N,Z,C,V}
- req1_*/rsp1_*  same set for requester 1
- flags_q  out  4  architectural NZCV register

Behaviour:
- Reset (reset==0 at a clock edge):
  - rsp0_valid=rsp1_valid=0; rsp*_result=0; rsp*_flags=0; flags_q=0.
  - Priority pointer = PRIO_RST.
  - Any held or in-flight response is discarded.
  - req*_ready=0 while reset is low.
- Per-port buffer states: EMPTY, FULL (rspN_valid = FULL).
- Port N is eligible when reqN_valid=1 and (buffer N EMPTY, or FULL with rspN_ready=1 this cycle). A buffer drained in a cycle may be refilled in that same cycle.
- Grant:
  - At most one grant per cycle (single ALU).
  - If both ports are eligible, the port indicated by the priority pointer wins.
  - After any grant, the pointer moves to the other port.
  - The pointer is unchanged in cycles with no grant.
- reqN_ready=1 exactly when port N is granted. It is combinational from the valids, buffer states and rspN_ready. There is no combinational path from reqN_valid to the other port's ready except through arbitration.
- On the grant edge:
  - The ALU is driven from the winner's a/b/ctrl.
  - Result and flags are captured into the winner's buffer, which goes FULL.
  - rspN_valid rises the next cycle. Latency is 1 cycle from handshake to response.
- Buffer FULL with rspN_ready=1 and no new grant: buffer goes EMPTY next cycle.
- Buffer FULL with rspN_ready=0: contents stay stable and the port is not eligible (backpressure).
- flags_q:
  - Loaded from the ALU flags on the grant edge when the winner's sf=1; otherwise it holds.
  - All four flags are taken as produced by the ALU, including the ALU forcing C=V=0 for logic and multiply ops.
- ALU codes are passed through unchanged:
  - 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 110 SMUL, 111 MUL.
  - 101 yields result 0 and flags 0100; no error is signalled.
- Stable-request rule: a requester holds valid and payload until ready. The arbiter does not check this.
- Throughput: 1 op/cycle total. A single requester with rsp_ready tied high sustains 1 op/cycle when the other port is idle.

Decomposition:
- Shared package holds:
  - ALU control localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_SMUL, ALU_MUL).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - Buffer state encoding.
- One sub-module: the existing alu, instantiated once, driven by the grant mux.
- Arbiter, buffers and flags register stay in this module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both valids high.
  - Required: both ready=0 and both rsp_valid=0.
  - Required: flags_q=0000 throughout reset and in the first cycle after release (buffers empty until the first grant edge).
  - First grant goes to port 0.
- Single op: req0 ADD a=0x7FFFFFFF b=1 sf=1.
  - Required: next cycle rsp0_result=0x80000000, rsp0_flags=1001, flags_q=1001.
- Contention: both valid every cycle, rsp_ready=1.
  - Port 0 ops: SUB 5-5, then AND.
  - Port 1 ops: MUL 3*4, then SMUL -3*4.
  - Required grant order 0,1,0,1.
  - Required results 0 (flags 0110), 12, AND result, 0xFFFFFFF4 (flags 1000).
- Backpressure: port 1 FULL with rsp1_ready=0 for 3 cycles while req1_valid=1.
  - Required: req1_ready=0 and rsp1_result stable for those cycles.
  - Required: port 0 is granted every cycle meanwhile.
- Drain+refill: rsp0_ready=1 and req0_valid=1 in the same cycle.
  - Required: req0_ready=1 and rsp0_valid stays 1 with the new result next cycle.
- Reset mid-flight: reset=0 while both buffers are FULL.
  - Required: rsp_valid=0 and flags_q=0000 next cycle; priority back to port 0.
